mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one backing memory between an instruction-fetch port
// and a data port; data wins ties unless the fetch port has waited STARVE_LIMIT grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        stall_o,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              fetch_starved;

  assign fetch_starved = if_req_i && (starve_cnt == LIMIT);

  assign mem_enable_o = (state == BUSY_IF) || (state == BUSY_DM);
  assign mem_addr_o   = addr_q;
  assign mem_write_o  = we_q;
  assign mem_data_o   = wdata_q;

  // Gated by reset so every output reads 0 while rst_i is low.
  assign stall_o = rst_i & ((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o));

  // NOTE: the latched address/data registers are reset too, because the memory
  // port is driven straight from them and must read 0 during reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_data_o  <= '0;
      dm_rdata_o <= '0;
      if_ack_o   <= 1'b0;
      dm_ack_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge value of state and starve_cnt regardless of statement order.
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req_i && !fetch_starved) begin
            state   <= BUSY_DM;
            addr_q  <= dm_addr_i;
            we_q    <= dm_we_i;
            wdata_q <= dm_wdata_i;
            if (!if_req_i)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (if_req_i) begin
            state      <= BUSY_IF;
            addr_q     <= if_addr_i;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ack_i) begin
            if_data_o <= mem_data_i;
            if_ack_o  <= 1'b1;
            state     <= DONE;
          end
        end
        BUSY_DM: begin
          if (mem_ack_i) begin
            if (!we_q)
              dm_rdata_o <= mem_data_i;
            dm_ack_o <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
